csp_channel_merge: RTL and testbench
====================================

CSP_CHANNEL_MERGE -- requirements
Module: csp_channel_merge

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of input channels, range 2..16.
REQ-002 SHALL have parameter base, default 4: radix of the 1-of-base token; legal data values are 0..base-1.
REQ-003 SHALL have parameter numBits, default 3: signed channel data width; must hold base-1 and -1.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in$data, input, NUM_IN*numBits bits: packed signed input channel data; slot i is bits [i*numBits +: numBits]; -1 means neutral (no token).
REQ-007 SHALL have port in$enable, output, NUM_IN bits: per-input accept pulse; token i is consumed on the edge where in$enable[i]=1.
REQ-008 SHALL have port out$data, output signed, numBits bits: merged channel data; -1 when empty.
REQ-009 SHALL have port out$src, output, $clog2(NUM_IN) bits: index of the input that supplied out$data.
REQ-010 SHALL have port out$enable, input, 1 bit: downstream ready; the token transfers on the edge where out$data!=-1 and out$enable=1.
REQ-011 SHALL have port err_clr, input, 1 bit: synchronous clear of protocol_err.
REQ-012 SHALL have port protocol_err, output, 1 bit: sticky flag for an illegal input value.

Function
REQ-013 SHALL treat input i as requesting when its slot is neither -1 nor illegal (valid range 0..base-1).
REQ-014 SHALL implement FSM states EMPTY (out$data=-1) and FULL (one token buffered in the output register).
REQ-015 EMPTY: if at least one input is requesting, SHALL grant exactly one input by round-robin, assert in$enable for that input only (combinational, same cycle), and load its data and index into the output register; next state FULL.
REQ-016 FULL with out$enable=0: SHALL hold out$data and out$src stable, keep in$enable=0, and stay in FULL.
REQ-017 FULL with out$enable=1: the token leaves; in the same cycle SHALL grant a new requester if one exists and stay FULL, otherwise go to EMPTY. This gives full throughput of one token per cycle.
REQ-018 Latency SHALL be 1 cycle from an input grant edge to the token appearing on out$data.
REQ-019 Round-robin SHALL search starting at index last_grant+1 mod NUM_IN; last_grant updates only when a grant occurs; the search wraps from NUM_IN-1 to 0.
REQ-020 SHALL never assert more than one in$enable bit in any cycle.
REQ-021 SHALL never assert in$enable[i] while slot i is -1 or illegal.
REQ-022 Illegal slot value (< -1 or >= base) SHALL set protocol_err on the next edge; that slot is never granted; other inputs continue to be served.
REQ-023 If err_clr and a new error occur in the same cycle, protocol_err SHALL remain 1 (set wins).
REQ-024 out$data SHALL never take a value other than -1 or 0..base-1.

Reset
REQ-025 While RESET=1, asynchronously: FSM=EMPTY, out$data=-1, out$src=0, last_grant=NUM_IN-1 (so index 0 is searched first), protocol_err=0.
REQ-026 While RESET=1, in$enable SHALL be all zeros regardless of inputs.
REQ-027 Reset asserted mid-operation SHALL discard any buffered token without asserting any in$enable.
REQ-028 The first grant after reset release SHALL occur no earlier than the first rising CLK edge with RESET=0.

Structure
REQ-029 The neutral value (-1), the legality check function, and the FSM state enum SHALL live in the shared package csp_chan_pkg, which is reused by the node/channel converters.
REQ-030 The round-robin priority picker SHALL be a sub-module rr_pick (request vector and last index in; one-hot grant and index out; combinational); all state stays in csp_channel_merge.

Verification
REQ-031 Reset then idle: all inputs -1 -> out$data=-1, in$enable=0, protocol_err=0 for 10 cycles.
REQ-032 Single input: NUM_IN=4, slot2=3, out$enable=1 -> in$enable=4'b0100 on cycle 0; out$data=3, out$src=2 on cycle 1.
REQ-033 Fairness: all four slots hold tokens continuously, out$enable=1 -> grants in order 0,1,2,3,0,... with one token per cycle.
REQ-034 Backpressure: out$enable=0 for 5 cycles while FULL -> out$data held stable, in$enable=0; out$enable then goes to 1 -> the next grant occurs in the same cycle.
REQ-035 Error: slot1=base (illegal) while slot0=1 -> protocol_err=1 next cycle; slot1 never granted; slot0 still served; err_clr pulse -> protocol_err=0.
REQ-036 Reset mid-FULL: RESET asserted between clock edges -> out$data=-1 immediately; after release, input 0 has first priority.

Source files
------------

// File: rtl/csp_chan_pkg.sv
// csp_chan_pkg: shared 1-of-N channel definitions used by the merge and the node/channel converters.
package csp_chan_pkg;
    localparam int CHAN_NEUTRAL = -1;
    typedef enum logic {CH_EMPTY, CH_FULL} chan_state_e;
    function automatic logic chan_legal(input int v, input int radix);
        return v >= 0 && v < radix;
    endfunction
endpackage

// File: rtl/csp_channel_merge_rr_pick.sv
// rr_pick: combinational round-robin picker, searching from last_i+1 and wrapping at N-1.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [IW-1:0] j;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(last_i) + k) % N);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = j;
                gnt_o[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/csp_channel_merge.sv
// csp_channel_merge: fair N-to-1 merge of 1-of-base channels into a one-token output buffer.
module csp_channel_merge
    import csp_chan_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int base    = 4,
    parameter int numBits = 3
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_IN*numBits-1:0]     in_data,
    output logic [NUM_IN-1:0]             in_enable,
    output logic signed [numBits-1:0]     out_data,
    output logic [$clog2(NUM_IN)-1:0]     out_src,
    input  logic                          out_enable,
    input  logic                          err_clr,
    output logic                          protocol_err
);
    localparam int IW = $clog2(NUM_IN);

    logic signed [numBits-1:0] slot [NUM_IN];
    logic [NUM_IN-1:0]         req, bad, gnt;
    logic [IW-1:0]             gnt_idx, last_q, src_q;
    logic                      any, take, err_q;
    logic signed [numBits-1:0] sel, data_q;
    chan_state_e               state_q;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_slot
        assign slot[g] = in_data[g*numBits +: numBits];
        assign req[g]  = chan_legal(int'(slot[g]), base);
        assign bad[g]  = !req[g] && int'(slot[g]) != CHAN_NEUTRAL;
    end

    rr_pick #(.N(NUM_IN), .IW(IW)) u_pick (
        .req_i (req),
        .last_i(last_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (any)
    );

    assign take      = !RESET && any && (state_q == CH_EMPTY || out_enable);
    assign in_enable = {NUM_IN{take}} & gnt;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (gnt[i]) sel = slot[i];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= CH_EMPTY;
            data_q  <= numBits'(CHAN_NEUTRAL);
            src_q   <= '0;
            last_q  <= IW'(NUM_IN - 1);
            err_q   <= 1'b0;
        end else begin
            if (take) begin
                state_q <= CH_FULL;
                data_q  <= sel;
                src_q   <= gnt_idx;
                last_q  <= gnt_idx;
            end else if (state_q == CH_FULL && out_enable) begin
                state_q <= CH_EMPTY;
                data_q  <= numBits'(CHAN_NEUTRAL);
            end
            err_q <= (|bad) || (err_q && !err_clr);
        end
    end

    assign out_data     = data_q;
    assign out_src      = src_q;
    assign protocol_err = err_q;
endmodule

// File: tb/tb_csp_channel_merge.sv
// tb_csp_channel_merge: scoreboard bench with a cycle model of the round-robin merge.
module tb_csp_channel_merge;
    localparam int N = 4;
    localparam int W = 3;
    localparam int B = 4;

    typedef struct {int data; int src;} tok_t;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic [N*W-1:0]      din;
    logic [N-1:0]        en;
    logic signed [W-1:0] odata;
    logic [1:0]          osrc;
    logic                oe = 1'b0;
    logic                clr = 1'b0;
    logic                perr;

    int   n_cmp = 0;
    int   n_bad = 0;
    tok_t sb[$];
    int   m_full, m_last, m_err;

    always #5 CLK = ~CLK;

    csp_channel_merge #(.NUM_IN(N), .base(B), .numBits(W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_data     (din),
        .in_enable   (en),
        .out_data    (odata),
        .out_src     (osrc),
        .out_enable  (oe),
        .err_clr     (clr),
        .protocol_err(perr)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int slot(input logic [N*W-1:0] d, input int i);
        logic signed [W-1:0] t;
        t = d[i*W +: W];
        return int'(t);
    endfunction

    function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int e);
        return {W'(e), W'(c), W'(b), W'(a)};
    endfunction

    task automatic cyc(input int a, input int b, input int c, input int e, input logic o, input logic cl);
        logic [N-1:0] xe;
        int           g;
        logic         bad;
        tok_t         t;
        @(negedge CLK);
        din = pk(a, b, c, e);
        oe  = o;
        clr = cl;
        #1;
        xe  = '0;
        g   = -1;
        bad = 1'b0;
        for (int i = 0; i < N; i++)
            if (slot(din, i) < -1 || slot(din, i) >= B) bad = 1'b1;
        if (!m_full || o)
            for (int k = 1; k <= N; k++)
                if (g < 0 && slot(din, (m_last + k) % N) >= 0 && slot(din, (m_last + k) % N) < B)
                    g = (m_last + k) % N;
        if (g >= 0) xe[g] = 1'b1;
        chk("in_enable", en, xe);
        if (m_full && o) begin
            t = sb.pop_front();
            chk("xfer_data", odata, t.data);
            chk("xfer_src", osrc, t.src);
            m_full = 0;
        end else if (m_full) begin
            chk("hold_data", odata, sb[0].data);
            chk("hold_src", osrc, sb[0].src);
        end else begin
            chk("empty_data", odata, -1);
        end
        chk("protocol_err", perr, m_err);
        if (g >= 0) begin
            sb.push_back('{slot(din, g), g});
            m_full = 1;
            m_last = g;
        end
        m_err = (bad || (m_err && !cl)) ? 1 : 0;
    endtask

    // Reset is raised between edges with tokens present, so nothing may be granted.
    task automatic do_reset();
        @(negedge CLK);
        din = pk(1, 2, 3, 0);
        #2 RESET = 1'b1;
        #1;
        chk("rst_out_data", odata, -1);
        chk("rst_src", osrc, 0);
        chk("rst_enable", en, 0);
        chk("rst_err", perr, 0);
        @(negedge CLK);
        chk("rst_hold_enable", en, 0);
        chk("rst_hold_data", odata, -1);
        din    = pk(-1, -1, -1, -1);
        RESET  = 1'b0;
        m_full = 0;
        m_last = N - 1;
        m_err  = 0;
        sb.delete();
    endtask

    initial begin
        din = pk(-1, -1, -1, -1);
        do_reset();
        repeat (10) cyc(-1, -1, -1, -1, 1'b1, 1'b0);
        cyc(-1, -1, 3, -1, 1'b1, 1'b0);
        repeat (2) cyc(-1, -1, -1, -1, 1'b1, 1'b0);
        repeat (8) cyc(1, 2, 3, 0, 1'b1, 1'b0);
        repeat (5) cyc(1, 2, 3, 0, 1'b0, 1'b0);
        repeat (3) cyc(1, 2, 3, 0, 1'b1, 1'b0);
        repeat (4) cyc(1, 4, -1, -1, 1'b1, 1'b0);
        cyc(1, -2, -1, -1, 1'b1, 1'b1);
        cyc(-1, -1, -1, -1, 1'b1, 1'b1);
        cyc(-1, -1, -1, -1, 1'b1, 1'b0);
        cyc(-1, -1, 2, -1, 1'b1, 1'b0);
        cyc(-1, -1, -1, -1, 1'b0, 1'b0);
        do_reset();
        repeat (6) cyc(3, 2, 1, 0, 1'b1, 1'b0);
        repeat (2) cyc(-1, -1, -1, -1, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
